mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
Iterative multiply/divide unit feeding the dual-write-port register file. It consumes the two register read operands and computes the 64-bit product, or the quotient and remainder. It then writes both halves back in the same cycle through write ports 1 (LO) and 2 (HI). One operation is in flight at a time; `busy` stalls issue.

Parameters:
WIDTH, 32, operand/result width (product is 2*WIDTH)
CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  issue pulse; sampled only in IDLE
op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
rs_data  in  WIDTH  multiplicand / dividend (from read_data1)
rt_data  in  WIDTH  multiplier / divisor (from read_data2)
dst_lo  in  5  destination register for LO (product low / quotient)
dst_hi  in  5  destination register for HI (product high / remainder)
busy  out  1  high from the edge after start until return to IDLE
done  out  1  one-cycle pulse, coincident with the write-back
div_by_zero  out  1  one-cycle pulse with done when a divide has divisor 0
write_reg1  out  5  to register file write port 1 (LO)
write_data1  out  WIDTH  LO result
reg_write1  out  1  port 1 write enable
write_reg2  out  5  to register file write port 2 (HI)
write_data2  out  WIDTH  HI result
reg_write2  out  1  port 2 write enable

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous, active-high.
- Reset: state IDLE, counter 0. All outputs 0, including write_reg*/write_data*. Reset mid-operation aborts it with no write-back, and `busy` is 0 in the cycle after the reset edge.
- States: IDLE -> CALC -> FIX -> WRITE -> IDLE.
- IDLE:
  - On an edge with start=1: latch op, dst_lo, dst_hi and operand magnitudes. For signed ops, take the absolute value and record the result signs. Clear the counter and go to CALC.
  - Divide with rt_data==0: go straight to WRITE instead.
- CALC:
  - Multiply: one radix-2 shift-add step per cycle.
  - Divide: one restoring shift-subtract step per cycle.
  - Exactly WIDTH steps (32), then go to FIX.
- FIX:
  - Negate the product if the operand signs differ (MULT).
  - Negate the quotient if the signs differ; the remainder takes the dividend's sign (DIV).
  - Go to WRITE.
- WRITE (one cycle):
  - done=1.
  - write_reg1=dst_lo, write_data1=LO; write_reg2=dst_hi, write_data2=HI.
  - reg_write1 and reg_write2 asserted, subject to the suppression rules below.
  - Next edge: IDLE.
- Latency: start sampled at edge E0; WRITE outputs are visible after edge E33, and the register file captures them at E34. Divide-by-zero: WRITE is visible after E0.
- Write suppression:
  - reg_write1=0 if dst_lo==0; reg_write2=0 if dst_hi==0.
  - If dst_lo==dst_hi (nonzero), reg_write1=0, so HI wins.
- Divide by zero: LO=all ones, HI=rs_data unmodified, div_by_zero=1.
- Overflow: DIV of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0; no flag.
- Outside WRITE: done, reg_write1/2 and div_by_zero are 0. write_reg*/write_data* hold their last values.
- start while busy is ignored, with no queuing.
- Operands are sampled only at the start edge; later changes on rs_data/rt_data have no effect.

Optional Feature:
EARLY_TERM_EN
- Defined: a multiply performs max(1, p) CALC steps, where p = index of the highest set bit of |multiplier| plus 1. A zero multiplier takes 1 step. Latency shrinks accordingly, and results are identical. Divides are unaffected.
- Undefined: always WIDTH steps.

Test Plan:
1. MULTU 0xFFFFFFFF*0xFFFFFFFF, dst_lo=8, dst_hi=9 -> after E33: done=1, write_data1=0x00000001, write_data2=0xFFFFFFFE, both reg_write=1; busy=0 after E34.
2. MULT rs=0xFFFFFFFD(-3), rt=7 -> LO=0xFFFFFFEB, HI=0xFFFFFFFF; DIV rs=0xFFFFFFF9(-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. DIVU rs=100, rt=0 -> after E0: done=1, div_by_zero=1, LO=0xFFFFFFFF, HI=0x00000064; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0, div_by_zero=0.
4. Issue MULTU 6*7, pulse start again at cycle 5 with other operands -> only one done, LO=42; rst at cycle 10 of a new op -> no reg_write ever, busy=0 the next cycle, all outputs 0.
5. dst_lo=0, dst_hi=5 -> reg_write1=0, reg_write2=1; dst_lo=dst_hi=12 -> reg_write1=0, reg_write2=1 with HI data.
6. With EARLY_TERM_EN: MULTU 5*3 -> 2 CALC steps, done visible after E3, LO=15, HI=0; without it, same result after E33.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Issue/write-back bundle between the register file side and mult_div_unit.
// Issue side drives operands and start; the unit returns busy/done and two write ports.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [4:0]       dst_lo;
  logic [4:0]       dst_hi;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [4:0]       write_reg1;
  logic [WIDTH-1:0] write_data1;
  logic             reg_write1;
  logic [4:0]       write_reg2;
  logic [WIDTH-1:0] write_data2;
  logic             reg_write2;

  modport master (
    output start, op, rs_data, rt_data, dst_lo, dst_hi,
    input  busy, done, div_by_zero,
    input  write_reg1, write_data1, reg_write1,
    input  write_reg2, write_data2, reg_write2
  );

  modport slave (
    input  start, op, rs_data, rt_data, dst_lo, dst_hi,
    output busy, done, div_by_zero,
    output write_reg1, write_data1, reg_write1,
    output write_reg2, write_data2, reg_write2
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU: WIDTH+2 cycles start-to-write (1 for divide by zero); start ignored while busy.
// EARLY_TERM_EN: multiplies run only as many steps as the multiplier magnitude has significant bits.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  mult_div_unit_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, WRITE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] steps;
  logic [1:0]       op_q;
  logic [4:0]       dst_lo_q;
  logic [4:0]       dst_hi_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             neg_lo;
  logic             neg_hi;

  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic             rw1_q;
  logic             rw2_q;
  logic [4:0]       wr1_q;
  logic [4:0]       wr2_q;
  logic [WIDTH-1:0] wd1_q;
  logic [WIDTH-1:0] wd2_q;

  // Issue-side operand conditioning
  logic             rs_neg;
  logic             rt_neg;
  logic [WIDTH-1:0] rs_abs;
  logic [WIDTH-1:0] rt_abs;
  logic [CNT_W-1:0] first_steps;

  always_comb begin
    rs_neg      = bus.op[0] & bus.rs_data[WIDTH-1];
    rt_neg      = bus.op[0] & bus.rt_data[WIDTH-1];
    rs_abs      = rs_neg ? -bus.rs_data : bus.rs_data;
    rt_abs      = rt_neg ? -bus.rt_data : bus.rt_data;
    first_steps = CNT_W'(WIDTH);
`ifdef EARLY_TERM_EN
    if (!bus.op[1]) begin
      first_steps = CNT_W'(1);
      for (int i = 1; i < WIDTH; i++) begin
        if (rt_abs[i]) first_steps = CNT_W'(i + 1);
      end
    end
`endif
  end

  // Multiply walks the multiplier MSB-first from bit steps-1, so a shortened run needs no realignment.
  logic [IDX_W-1:0]   bit_idx;
  logic [2*WIDTH-1:0] prod_next;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   fix_lo;
  logic [WIDTH-1:0]   fix_hi;

  always_comb begin
    bit_idx   = IDX_W'(steps - cnt - CNT_W'(1));
    prod_next = {acc_hi, acc_lo} << 1;
    if (b_q[bit_idx]) prod_next = prod_next + {{WIDTH{1'b0}}, a_q};
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    prod_neg  = -{acc_hi, acc_lo};
    if (op_q[1]) begin
      fix_lo = neg_lo ? -acc_lo : acc_lo;
      fix_hi = neg_hi ? -acc_hi : acc_hi;
    end else begin
      fix_lo = neg_lo ? prod_neg[WIDTH-1:0]       : acc_lo;
      fix_hi = neg_lo ? prod_neg[2*WIDTH-1:WIDTH] : acc_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      steps    <= '0;
      op_q     <= '0;
      dst_lo_q <= '0;
      dst_hi_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      rw1_q    <= 1'b0;
      rw2_q    <= 1'b0;
      wr1_q    <= '0;
      wr2_q    <= '0;
      wd1_q    <= '0;
      wd2_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q     <= bus.op;
            dst_lo_q <= bus.dst_lo;
            dst_hi_q <= bus.dst_hi;
            a_q      <= rs_abs;
            b_q      <= rt_abs;
            acc_hi   <= '0;
            acc_lo   <= bus.op[1] ? rs_abs : '0;
            neg_lo   <= rs_neg ^ rt_neg;
            neg_hi   <= bus.op[1] ? rs_neg : (rs_neg ^ rt_neg);
            cnt      <= '0;
            steps    <= first_steps;
            busy_q   <= 1'b1;
            if (bus.op[1] && bus.rt_data == '0) begin
              // Divide by zero skips the datapath; HI returns the raw dividend.
              state  <= WRITE;
              done_q <= 1'b1;
              dbz_q  <= 1'b1;
              wr1_q  <= bus.dst_lo;
              wr2_q  <= bus.dst_hi;
              wd1_q  <= '1;
              wd2_q  <= bus.rs_data;
              rw1_q  <= (bus.dst_lo != 5'd0) && (bus.dst_lo != bus.dst_hi);
              rw2_q  <= (bus.dst_hi != 5'd0);
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (op_q[1]) begin
            if (!div_diff[WIDTH]) begin
              acc_hi <= div_diff[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            {acc_hi, acc_lo} <= prod_next;
          end
          if (cnt == steps - CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          state  <= WRITE;
          done_q <= 1'b1;
          wr1_q  <= dst_lo_q;
          wr2_q  <= dst_hi_q;
          wd1_q  <= fix_lo;
          wd2_q  <= fix_hi;
          // Same destination on both ports: HI wins.
          rw1_q  <= (dst_lo_q != 5'd0) && (dst_lo_q != dst_hi_q);
          rw2_q  <= (dst_hi_q != 5'd0);
        end
        WRITE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          dbz_q  <= 1'b0;
          rw1_q  <= 1'b0;
          rw2_q  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.write_reg1  = wr1_q;
  assign bus.write_data1 = wd1_q;
  assign bus.reg_write1  = rw1_q;
  assign bus.write_reg2  = wr2_q;
  assign bus.write_data2 = wd2_q;
  assign bus.reg_write2  = rw2_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected write-back pushed at issue, popped on done.
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(32)) bus();

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [4:0]  wr1;
    logic [4:0]  wr2;
    logic        rw1;
    logic        rw2;
    logic        dbz;
  } res_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  dlo;
    logic [4:0]  dhi;
    res_t        e;
  } vec_t;

  res_t exp_q[$];
  int   lat_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic res_t capture();
    res_t r;
    r.lo  = bus.write_data1;
    r.hi  = bus.write_data2;
    r.wr1 = bus.write_reg1;
    r.wr2 = bus.write_reg2;
    r.rw1 = bus.reg_write1;
    r.rw2 = bus.reg_write2;
    r.dbz = bus.div_by_zero;
    return r;
  endfunction

  function automatic res_t model(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [4:0] dlo, input logic [4:0] dhi);
    res_t r;
    logic [63:0] p;
    longint sa, sb, q, m;
    r.wr1 = dlo;
    r.wr2 = dhi;
    r.rw1 = (dlo != 5'd0) && (dlo != dhi);
    r.rw2 = (dhi != 5'd0);
    r.dbz = 1'b0;
    sa = longint'($signed(rs));
    sb = longint'($signed(rt));
    p  = '0;
    if (op[1] && rt == 32'd0) begin
      r.lo  = 32'hFFFF_FFFF;
      r.hi  = rs;
      r.dbz = 1'b1;
    end else begin
      case (op)
        2'b00: p = {32'd0, rs} * {32'd0, rt};
        2'b01: p = 64'(sa * sb);
        2'b10: p = {rs % rt, rs / rt};
        default: begin
          q = sa / sb;
          m = sa % sb;
          p = {m[31:0], q[31:0]};
        end
      endcase
      r.lo = p[31:0];
      r.hi = p[63:32];
    end
    return r;
  endfunction

  // Edges after the start edge until done is visible.
  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] rt);
    int steps;
    logic [31:0] mag;
    mag = (op == 2'b01 && rt[31]) ? -rt : rt;
    if (op[1] && rt == 32'd0) return 0;
    steps = 32;
`ifdef EARLY_TERM_EN
    if (!op[1]) begin
      steps = 1;
      for (int i = 0; i < 32; i++) if (mag[i]) steps = i + 1;
    end
`endif
    return steps + 1;
  endfunction

  task automatic issue(input vec_t v);
    @(negedge clk);
    bus.op      = v.op;
    bus.rs_data = v.rs;
    bus.rt_data = v.rt;
    bus.dst_lo  = v.dlo;
    bus.dst_hi  = v.dhi;
    bus.start   = 1'b1;
    exp_q.push_back(v.e);
    lat_q.push_back(exp_lat(v.op, v.rt));
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.rs_data = $urandom;
    bus.rt_data = $urandom;
  endtask

  task automatic wait_done(output res_t o, output int lat, output bit to);
    to  = 1'b1;
    lat = 0;
    o   = '0;
    for (int k = 0; k < 100; k++) begin
      if (bus.done === 1'b1) begin
        o  = capture();
        to = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    res_t o;
    repeat (3) @(posedge clk);
    #1;
    o = capture();
    n_chk++;
    if (o !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h busy=%b done=%b, want all zero", o, bus.busy, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_table(input string name, input vec_t tbl[]);
    res_t o, e;
    int   l, el;
    bit   to;
    foreach (tbl[i]) begin
      issue(tbl[i]);
      wait_done(o, l, to);
      e  = exp_q.pop_front();
      el = lat_q.pop_front();
      n_chk++;
      if (to || o !== e) begin
        n_fail++;
        $display("FAIL %s[%0d] result: got %h timeout=%b, want %h", name, i, o, to, e);
      end
      n_chk++;
      if (l !== el) begin
        n_fail++;
        $display("FAIL %s[%0d] latency: got %0d, want %0d", name, i, l, el);
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s[%0d] idle_after_write: busy=%b done=%b, want 0 0", name, i, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_mult();
    vec_t t[];
    t = new[3];
    t[0] = '{op:2'b00, rs:32'hFFFF_FFFF, rt:32'hFFFF_FFFF, dlo:5'd8, dhi:5'd9,
             e:'{lo:32'h0000_0001, hi:32'hFFFF_FFFE, wr1:5'd8, wr2:5'd9, rw1:1'b1, rw2:1'b1, dbz:1'b0}};
    t[1] = '{op:2'b01, rs:32'hFFFF_FFFD, rt:32'd7, dlo:5'd1, dhi:5'd2,
             e:'{lo:32'hFFFF_FFEB, hi:32'hFFFF_FFFF, wr1:5'd1, wr2:5'd2, rw1:1'b1, rw2:1'b1, dbz:1'b0}};
    t[2] = '{op:2'b01, rs:32'h8000_0000, rt:32'h8000_0000, dlo:5'd3, dhi:5'd4,
             e:'{lo:32'h0000_0000, hi:32'h4000_0000, wr1:5'd3, wr2:5'd4, rw1:1'b1, rw2:1'b1, dbz:1'b0}};
    run_table("mult", t);
  endtask

  task automatic test_div();
    vec_t t[];
    t = new[4];
    t[0] = '{op:2'b11, rs:32'hFFFF_FFF9, rt:32'd2, dlo:5'd5, dhi:5'd6,
             e:'{lo:32'hFFFF_FFFD, hi:32'hFFFF_FFFF, wr1:5'd5, wr2:5'd6, rw1:1'b1, rw2:1'b1, dbz:1'b0}};
    t[1] = '{op:2'b11, rs:32'h8000_0000, rt:32'hFFFF_FFFF, dlo:5'd7, dhi:5'd8,
             e:'{lo:32'h8000_0000, hi:32'h0000_0000, wr1:5'd7, wr2:5'd8, rw1:1'b1, rw2:1'b1, dbz:1'b0}};
    t[2] = '{op:2'b10, rs:32'd100, rt:32'd7, dlo:5'd10, dhi:5'd11,
             e:'{lo:32'd14, hi:32'd2, wr1:5'd10, wr2:5'd11, rw1:1'b1, rw2:1'b1, dbz:1'b0}};
    t[3] = '{op:2'b11, rs:32'd7, rt:32'hFFFF_FFFE, dlo:5'd12, dhi:5'd13,
             e:'{lo:32'hFFFF_FFFD, hi:32'd1, wr1:5'd12, wr2:5'd13, rw1:1'b1, rw2:1'b1, dbz:1'b0}};
    run_table("div", t);
  endtask

  task automatic test_div_by_zero();
    vec_t t[];
    t = new[2];
    t[0] = '{op:2'b10, rs:32'd100, rt:32'd0, dlo:5'd14, dhi:5'd15,
             e:'{lo:32'hFFFF_FFFF, hi:32'h0000_0064, wr1:5'd14, wr2:5'd15, rw1:1'b1, rw2:1'b1, dbz:1'b1}};
    t[1] = '{op:2'b11, rs:32'hFFFF_FFFB, rt:32'd0, dlo:5'd16, dhi:5'd17,
             e:'{lo:32'hFFFF_FFFF, hi:32'hFFFF_FFFB, wr1:5'd16, wr2:5'd17, rw1:1'b1, rw2:1'b1, dbz:1'b1}};
    run_table("divzero", t);
  endtask

  task automatic test_suppress();
    vec_t t[];
    t = new[2];
    t[0] = '{op:2'b00, rs:32'h0001_0000, rt:32'h0003_0000, dlo:5'd0, dhi:5'd5,
             e:'{lo:32'h0, hi:32'h3, wr1:5'd0, wr2:5'd5, rw1:1'b0, rw2:1'b1, dbz:1'b0}};
    t[1] = '{op:2'b10, rs:32'd50, rt:32'd8, dlo:5'd12, dhi:5'd12,
             e:'{lo:32'd6, hi:32'd2, wr1:5'd12, wr2:5'd12, rw1:1'b0, rw2:1'b1, dbz:1'b0}};
    run_table("suppress", t);
  endtask

  task automatic test_early_term();
    vec_t v;
    res_t o, e;
    int   l, el, want;
    bit   to;
`ifdef EARLY_TERM_EN
    want = 3;
`else
    want = 33;
`endif
    v = '{op:2'b00, rs:32'd5, rt:32'd3, dlo:5'd20, dhi:5'd21,
          e:'{lo:32'd15, hi:32'd0, wr1:5'd20, wr2:5'd21, rw1:1'b1, rw2:1'b1, dbz:1'b0}};
    issue(v);
    wait_done(o, l, to);
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    n_chk++;
    if (to || o !== e) begin
      n_fail++;
      $display("FAIL early_term result: got %h timeout=%b, want %h", o, to, e);
    end
    n_chk++;
    if (l !== want || el !== want) begin
      n_fail++;
      $display("FAIL early_term latency: got %0d, want %0d", l, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ignore_start();
    vec_t v;
    res_t e;
    int   ndone = 0;
    logic [31:0] lo = '0;
    v = '{op:2'b00, rs:32'd6, rt:32'd7, dlo:5'd3, dhi:5'd4,
          e:'{lo:32'd42, hi:32'd0, wr1:5'd3, wr2:5'd4, rw1:1'b1, rw2:1'b1, dbz:1'b0}};
    issue(v);
    for (int k = 1; k < 50; k++) begin
      @(negedge clk);
      bus.start = (k == 5);
      if (k == 5) begin
        bus.rs_data = 32'd9;
        bus.rt_data = 32'd9;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        ndone++;
        lo = bus.write_data1;
      end
    end
    e = exp_q.pop_front();
    void'(lat_q.pop_front());
    n_chk++;
    if (ndone !== 1) begin
      n_fail++;
      $display("FAIL ignore_start done_count: got %0d, want 1", ndone);
    end
    n_chk++;
    if (lo !== e.lo) begin
      n_fail++;
      $display("FAIL ignore_start lo: got %h, want %h", lo, e.lo);
    end
  endtask

  task automatic test_reset_abort();
    res_t o;
    bit   wrote = 1'b0;
    @(negedge clk);
    bus.op      = 2'b00;
    bus.rs_data = 32'd123;
    bus.rt_data = 32'd456;
    bus.dst_lo  = 5'd22;
    bus.dst_hi  = 5'd23;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    o = capture();
    n_chk++;
    if (o !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort outputs: got %h busy=%b done=%b, want all zero", o, bus.busy, bus.done);
    end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.reg_write1 || bus.reg_write2 || bus.done) wrote = 1'b1;
    end
    n_chk++;
    if (wrote !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort writeback: got write activity, want none");
    end
  endtask

  task automatic test_back_to_back();
    vec_t t[];
    t = new[10];
    foreach (t[i]) begin
      t[i].op  = 2'($urandom_range(0, 3));
      t[i].rs  = (i % 5 == 1) ? 32'($urandom_range(0, 50)) : $urandom;
      t[i].rt  = (i % 4 == 0) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom);
      t[i].dlo = 5'($urandom_range(0, 31));
      t[i].dhi = 5'($urandom_range(0, 31));
      t[i].e   = model(t[i].op, t[i].rs, t[i].rt, t[i].dlo, t[i].dhi);
    end
    run_table("b2b", t);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.rs_data = '0;
    bus.rt_data = '0;
    bus.dst_lo  = '0;
    bus.dst_hi  = '0;
    test_reset();
    test_mult();
    test_div();
    test_div_by_zero();
    test_suppress();
    test_early_term();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
